// File: rtl/tron_pkg.sv
// Shared encodings for the Tron arena display path: game states,
// colour codes, VGA timing constants and the render FSM states.
package tron_pkg;

    localparam logic [2:0] GS_MENU  = 3'd0;
    localparam logic [2:0] GS_PLAY1 = 3'd1;
    localparam logic [2:0] GS_PLAY2 = 3'd2;
    localparam logic [2:0] GS_PLAY3 = 3'd3;
    localparam logic [2:0] GS_OVER  = 3'd4;

    localparam logic [7:0] CLR_EMPTY = 8'h00;
    localparam logic [7:0] CLR_GRID  = 8'h01;
    localparam logic [7:0] CLR_BLUE  = 8'h02;
    localparam logic [7:0] CLR_RED   = 8'h03;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_TOTAL  = 525;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } rd_state_t;

    // Index width for a table of n entries (at least one bit).
    function automatic int col_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/render_line_buf.sv
// Ping-pong line buffer: back bank written by the row fetch,
// front bank read by the pixel path.
// Ports: i_clk, i_rst (async, active-high); i_wr_en/i_wr_col/i_wr_data
// write the back bank; i_swap exchanges banks and marks the new front
// valid; i_rd_col -> o_rd_data reads the front bank (combinational);
// o_front_valid reports whether the front bank holds a complete row.
module render_line_buf
    import tron_pkg::*;
#(
    parameter int GRID_W = 80
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [col_w(GRID_W)-1:0] i_wr_col,
    input  logic [7:0]               i_wr_data,
    input  logic                     i_swap,
    input  logic [col_w(GRID_W)-1:0] i_rd_col,
    output logic [7:0]               o_rd_data,
    output logic                     o_front_valid
);

    logic [7:0] r_bank0 [GRID_W];
    logic [7:0] r_bank1 [GRID_W];
    logic       r_sel;
    logic [1:0] r_valid;
    logic       w_back;

    // r_sel names the front bank; the other one is the back bank.
    assign w_back = ~r_sel;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            if (w_back)
                r_bank1[i_wr_col] <= i_wr_data;
            else
                r_bank0[i_wr_col] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sel   <= 1'b0;
            r_valid <= 2'b00;
        end else if (i_swap) begin
            r_sel          <= w_back;
            r_valid[w_back] <= 1'b1;
        end
    end

    assign o_rd_data     = r_sel ? r_bank1[i_rd_col] : r_bank0[i_rd_col];
    assign o_front_valid = r_valid[r_sel];

endmodule

// File: rtl/arena_render_reader.sv
// Arena render reader: prefetches the next grid row from the trail RAM
// during horizontal blank and serves one colour code per pixel.
// Ports: Clk, Reset (async, active-high); DrawX/DrawY/Game_State from
// the VGA/game logic; rd_addr/rd_en/rd_data to the trail RAM read port;
// cell_color (1-cycle registered) to the colour mapper; underrun is a
// sticky flag set when a row fetch misses its line start.
// Build option: define GRID_OVERLAY_EN to draw grid lines (CLR_GRID)
// over empty cells.
module arena_render_reader
    import tron_pkg::*;
#(
    parameter int GRID_W     = 80,
    parameter int GRID_H     = 60,
    parameter int CELL_SHIFT = 3,
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_TOTAL    = VGA_V_TOTAL,
    parameter int RD_LATENCY = 2,
    parameter int ADDR_W     = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [2:0]        Game_State,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [7:0]        rd_data,
    output logic [7:0]        cell_color,
    output logic              underrun
);

    localparam int CW = col_w(GRID_W);

    rd_state_t         r_state;
    rd_state_t         w_next;
    logic [9:0]        r_drawx_prev;
    logic [CW-1:0]     r_col;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_lat;
    logic              r_skip;
    logic              r_underrun;
    logic [RD_LATENCY-1:0] r_pv;
    logic [CW-1:0]     r_pc [RD_LATENCY];
    logic [7:0]        r_color;

    logic [9:0]        w_next_line;
    logic [9:0]        w_fetch_row;
    logic              w_need;
    logic              w_hblank;
    logic              w_dx0;
    logic              w_conflict;
    logic [ADDR_W-1:0] w_base;
    logic              w_rd_en;
    logic              w_swap;
    logic              w_front_valid;
    logic [7:0]        w_buf_data;
    logic [9:0]        w_cell_idx;
    logic              w_active;
    logic [7:0]        w_code;
    logic [7:0]        w_color;

    assign w_next_line = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
    assign w_fetch_row = w_next_line >> CELL_SHIFT;
    assign w_need      = (w_next_line < 10'(V_ACTIVE)) &&
                         (w_fetch_row < 10'(GRID_H));
    // Only the first cycle of DrawX==H_ACTIVE starts a fetch.
    assign w_hblank    = (DrawX == 10'(H_ACTIVE)) &&
                         (r_drawx_prev != 10'(H_ACTIVE));
    assign w_dx0       = (DrawX == 10'd0);
    assign w_conflict  = ((r_state == ST_FETCH) || (r_state == ST_DRAIN)) && w_dx0;
    // Row base computed once; loaded only on FETCH entry.
    assign w_base      = ADDR_W'(w_fetch_row) * ADDR_W'(GRID_W);

    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        w_swap  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_hblank && w_need)
                    w_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_rd_en = 1'b1;
                if (r_col == CW'(GRID_W - 1))
                    w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // A line start seen during the fetch forfeits its swap.
                if (r_lat == 3'(RD_LATENCY - 1))
                    w_next = (r_skip || w_conflict) ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (w_dx0) begin
                    w_swap = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_drawx_prev <= '0;
            r_col        <= '0;
            r_addr       <= '0;
            r_lat        <= '0;
            r_skip       <= 1'b0;
            r_underrun   <= 1'b0;
            r_pv         <= '0;
            r_color      <= CLR_EMPTY;
            for (int i = 0; i < RD_LATENCY; i++)
                r_pc[i] <= '0;
        end else begin
            r_drawx_prev <= DrawX;
            if ((r_state == ST_IDLE) && (w_next == ST_FETCH)) begin
                r_addr <= w_base;
                r_col  <= '0;
                r_skip <= 1'b0;
            end else if (w_rd_en) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_col  <= r_col + CW'(1);
            end
            if (r_state == ST_DRAIN)
                r_lat <= r_lat + 3'd1;
            else
                r_lat <= '0;
            if (w_conflict) begin
                r_skip     <= 1'b1;
                r_underrun <= 1'b1;
            end
            // Tracks each read so its return lands in the right column.
            r_pv[0] <= w_rd_en;
            r_pc[0] <= r_col;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pc[i] <= r_pc[i-1];
            end
            r_color <= w_color;
        end
    end

    render_line_buf #(
        .GRID_W (GRID_W)
    ) u_buf (
        .i_clk         (Clk),
        .i_rst         (Reset),
        .i_wr_en       (r_pv[RD_LATENCY-1]),
        .i_wr_col      (r_pc[RD_LATENCY-1]),
        .i_wr_data     (rd_data),
        .i_swap        (w_swap),
        .i_rd_col      (w_cell_idx[CW-1:0]),
        .o_rd_data     (w_buf_data),
        .o_front_valid (w_front_valid)
    );

    assign w_cell_idx = DrawX >> CELL_SHIFT;
    assign w_active   = (DrawX < 10'(H_ACTIVE)) &&
                        (DrawY < 10'(V_ACTIVE)) &&
                        (Game_State != GS_MENU);
    assign w_code     = (w_front_valid && (w_cell_idx < 10'(GRID_W))) ?
                        w_buf_data : CLR_EMPTY;

`ifdef GRID_OVERLAY_EN
    logic w_on_grid;
    assign w_on_grid = (DrawX[CELL_SHIFT-1:0] == '0) ||
                       (DrawY[CELL_SHIFT-1:0] == '0);
    assign w_color = !w_active ? CLR_EMPTY :
                     ((w_code == CLR_EMPTY) && w_on_grid) ? CLR_GRID : w_code;
`else
    assign w_color = w_active ? w_code : CLR_EMPTY;
`endif

    assign rd_en      = w_rd_en;
    assign rd_addr    = r_addr;
    assign cell_color = r_color;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_arena_render_reader.sv
// Testbench for arena_render_reader: directed scanline stimulus with
// queued expectations checked by a negedge monitor.
module tb_arena_render_reader;
    import tron_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [2:0]  Game_State = GS_PLAY1;
    logic [15:0] rd_addr;
    logic        rd_en;
    logic [7:0]  rd_data = '0;
    logic [7:0]  cell_color;
    logic        underrun;

    int n_vec = 0;
    int n_err = 0;
    int n_rd  = 0;

    logic [7:0]  exp_color_q [$];
    string       exp_name_q  [$];
    logic [15:0] exp_addr_q  [$];
    logic        chk_req = 1'b0;
    logic        chk_d   = 1'b0;
    logic [7:0]  mon_e;
    logic [15:0] mon_a;
    string       mon_nm;
    logic [7:0]  ram_p1 = '0;

`ifdef GRID_OVERLAY_EN
    localparam logic [7:0] OV_EXP = 8'h01;
`else
    localparam logic [7:0] OV_EXP = 8'h00;
`endif

    always #5 Clk = ~Clk;

    arena_render_reader dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .Game_State (Game_State),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .cell_color (cell_color),
        .underrun   (underrun)
    );

    function automatic logic [7:0] ram_val(input logic [15:0] a);
        return 8'(a + 16'd160);
    endfunction

    // Two-cycle trail RAM model.
    always @(posedge Clk) begin
        ram_p1  <= ram_val(rd_addr);
        rd_data <= ram_p1;
    end

    always @(posedge Clk) chk_d <= chk_req;

    always @(negedge Clk) begin
        if (chk_d) begin
            n_vec++;
            if (exp_color_q.size() == 0) begin
                n_err++;
                $display("FAIL color_unexpected: cell_color=%h with no expectation", cell_color);
            end else begin
                mon_e  = exp_color_q.pop_front();
                mon_nm = exp_name_q.pop_front();
                if (cell_color !== mon_e) begin
                    n_err++;
                    $display("FAIL %s: cell_color=%h expected %h", mon_nm, cell_color, mon_e);
                end
            end
        end
        if (rd_en === 1'b1) begin
            n_rd++;
            n_vec++;
            if (exp_addr_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: rd_addr=%0d with no read expected", rd_addr);
            end else begin
                mon_a = exp_addr_q.pop_front();
                if (rd_addr !== mon_a) begin
                    n_err++;
                    $display("FAIL rd_addr: got %0d expected %0d", rd_addr, mon_a);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic [2:0] gs,
                       input logic [7:0] e, input string nm);
        DrawX      = 10'(x);
        DrawY      = 10'(y);
        Game_State = gs;
        chk_req    = 1'b1;
        exp_color_q.push_back(e);
        exp_name_q.push_back(nm);
        step();
        chk_req = 1'b0;
    endtask

    task automatic push_fetch(input int row, input int ncols);
        for (int c = 0; c < ncols; c++)
            exp_addr_q.push_back(16'(row * 80 + c));
    endtask

    task automatic line_end(input int y, input int frow);
        if (frow >= 0)
            push_fetch(frow, 80);
        n_rd  = 0;
        DrawY = 10'(y);
        for (int x = 640; x < 760; x++) begin
            DrawX = 10'(x);
            step();
        end
        chk($sformatf("fetch_count_y%0d", y), n_rd, (frow >= 0) ? 80 : 0);
        DrawY = (y == 524) ? 10'd0 : 10'(y + 1);
        DrawX = 10'd0;
        step();
    endtask

    initial begin
        @(negedge Clk);
        chk("reset_rd_en", int'(rd_en), 0);
        chk("reset_rd_addr", int'(rd_addr), 0);
        chk("reset_color", int'(cell_color), 0);
        chk("reset_underrun", int'(underrun), 0);
        step();
        Reset = 1'b0;
        step();

        pix(16, 0, GS_PLAY1, 8'h00, "invalid_front");
        line_end(524, 0);
        pix(16, 0, GS_PLAY1, 8'hA2, "row0_x16");
        pix(700, 0, GS_PLAY1, 8'h00, "row0_x700");
        pix(0, 0, GS_PLAY1, 8'hA0, "row0_x0");
        pix(639, 0, GS_PLAY1, 8'hEF, "row0_x639");

        line_end(7, 1);
        pix(16, 8, GS_PLAY1, 8'hF2, "row1_x16");
        pix(8, 8, GS_PLAY1, 8'hF1, "row1_x8");

        line_end(479, -1);
        pix(16, 480, GS_PLAY1, 8'h00, "vblank_line");
        pix(16, 100, GS_PLAY1, 8'hF2, "no_swap_after_479");

        pix(16, 8, GS_MENU, 8'h00, "menu_blank");
        line_end(15, 2);
        pix(16, 16, GS_PLAY1, 8'h42, "row2_after_menu");

        push_fetch(3, 80);
        n_rd  = 0;
        DrawY = 10'd23;
        for (int x = 640; x < 680; x++) begin
            DrawX = 10'(x);
            step();
        end
        DrawY = 10'd24;
        DrawX = 10'd0;
        step();
        pix(16, 24, GS_PLAY1, 8'h42, "underrun_keeps_front");
        @(negedge Clk);
        chk("underrun_set", int'(underrun), 1);
        DrawX = 10'd1;
        repeat (60) step();
        chk("underrun_fetch_count", n_rd, 80);
        pix(16, 24, GS_PLAY1, 8'h42, "still_no_swap");
        line_end(31, 4);
        pix(16, 32, GS_PLAY1, 8'hE2, "row4_after_underrun");
        pix(256, 32, GS_PLAY1, OV_EXP, "overlay_zero_cell");
        pix(260, 33, GS_PLAY1, 8'h00, "empty_cell_off_grid");
        @(negedge Clk);
        chk("underrun_sticky", int'(underrun), 1);

        push_fetch(5, 40);
        n_rd  = 0;
        DrawY = 10'd39;
        for (int x = 640; x < 681; x++) begin
            DrawX = 10'(x);
            step();
        end
        Reset = 1'b1;
        @(negedge Clk);
        chk("midfetch_rd_en", int'(rd_en), 0);
        chk("midfetch_color", int'(cell_color), 0);
        chk("midfetch_count", n_rd, 40);
        chk("midfetch_underrun_clr", int'(underrun), 0);
        step();
        Reset = 1'b0;
        step();
        pix(16, 40, GS_PLAY1, 8'h00, "after_reset_invalid");
        line_end(47, 6);
        pix(16, 48, GS_PLAY1, 8'h82, "row6_after_reset");
        pix(16, 48, GS_OVER, 8'h82, "game_over_frozen");
        pix(8, 48, GS_PLAY1, 8'h81, "nonzero_beats_grid");

        repeat (3) step();
        chk("addr_queue_empty", exp_addr_q.size(), 0);
        chk("color_queue_empty", exp_color_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
